// File: rtl/vec_mem_seq_if.sv
// Bus bundle for vec_mem_seq: request handshake, store/load element streams,
// RAM port-A signals and status. The slave modport is the sequencer's view.
interface vec_mem_seq_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 7
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [ADDR_WIDTH-1:0] req_base;
    logic [ADDR_WIDTH-1:0] req_stride;
    logic [LEN_WIDTH-1:0]  req_len;

    logic                  st_valid;
    logic                  st_ready;
    logic [DATA_WIDTH-1:0] st_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_WIDTH-1:0] ld_data;

    logic                  mem_w;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    logic                  busy;
    logic                  done;

    modport master (
        output req_valid, req_store, req_base, req_stride, req_len,
        output st_valid, st_data, ld_ready, mem_dout,
        input  req_ready, st_ready, ld_valid, ld_data,
        input  mem_w, mem_addr, mem_din, busy, done
    );

    modport slave (
        input  req_valid, req_store, req_base, req_stride, req_len,
        input  st_valid, st_data, ld_ready, mem_dout,
        output req_ready, st_ready, ld_valid, ld_data,
        output mem_w, mem_addr, mem_din, busy, done
    );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer driving one RAM port with strided element addresses.
// Optional macro VMEM_STRIDE_EN enables non-unit strides; otherwise stride is fixed to 1.
module vec_mem_seq #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_mem_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] UNIT_STR = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
    logic [2:0]            credits_q, credits_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  done_q, done_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] fifo_mem [4];

    logic issue, wr_el, push, pop;
    logic [ADDR_WIDTH-1:0] req_stride_eff;

`ifdef VMEM_STRIDE_EN
    assign req_stride_eff = bus.req_stride;
`else
    logic unused_req_stride;
    assign unused_req_stride = ^bus.req_stride;
    assign req_stride_eff    = UNIT_STR;
`endif

    // A read is outstanding from issue until its element pops, capped by FIFO depth.
    assign issue = (state_q == LOAD) && (idx_q < len_q) && (credits_q < 3'd4);
    assign wr_el = (state_q == STORE) && bus.st_valid;
    assign push  = rd_pend_q;
    assign pop   = (count_q != 3'd0) && bus.ld_ready;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.st_ready  = (state_q == STORE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.mem_w     = wr_el;
    assign bus.mem_addr  = (issue || wr_el) ? addr_q : '0;
    assign bus.mem_din   = wr_el ? bus.st_data : '0;
    assign bus.ld_valid  = (count_q != 3'd0);
    assign bus.ld_data   = fifo_mem[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        len_d     = len_q;
        idx_d     = idx_q;
        pop_cnt_d = pop_cnt_q;
        credits_d = credits_q + {2'b00, issue} - {2'b00, pop};
        count_d   = count_q + {2'b00, push} - {2'b00, pop};
        wr_ptr_d  = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        rd_pend_d = issue;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d    = bus.req_base;
                    stride_d  = req_stride_eff;
                    len_d     = bus.req_len;
                    idx_d     = '0;
                    pop_cnt_d = '0;
                    // Zero-length requests complete without touching the RAM.
                    if (bus.req_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = bus.req_store ? STORE : LOAD;
                    end
                end
            end
            STORE: begin
                if (wr_el) begin
                    addr_d = addr_q + stride_q;
                    idx_d  = idx_q + LEN_ONE;
                    if (idx_q + LEN_ONE == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (issue) begin
                    addr_d = addr_q + stride_q;
                    idx_d  = idx_q + LEN_ONE;
                end
                if (pop) begin
                    pop_cnt_d = pop_cnt_q + LEN_ONE;
                    if (pop_cnt_q + LEN_ONE == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            pop_cnt_q <= '0;
            credits_q <= '0;
            rd_pend_q <= 1'b0;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            pop_cnt_q <= pop_cnt_d;
            credits_q <= credits_d;
            rd_pend_q <= rd_pend_d;
            done_q    <= done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Read data arrives one cycle after issue; storage needs no reset since
    // occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.mem_dout;
        end
    end
endmodule

// File: tb/tb_vec_mem_seq.sv
// Scoreboard bench for vec_mem_seq: stimulus queues expected writes/loads from
// base + i*stride arithmetic, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vec_mem_seq;
    localparam int AW    = 17;
    localparam int DW    = 32;
    localparam int LW    = 7;
    localparam int AMASK = (1 << AW) - 1;
`ifdef VMEM_STRIDE_EN
    localparam bit STRIDE_EN = 1'b1;
`else
    localparam bit STRIDE_EN = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_mem_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    vec_mem_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: unwritten words read back a salted address hash.
    logic [DW-1:0] ram     [0:AMASK];
    bit            written [0:AMASK];
    logic [DW-1:0] salt;
    int            cyc = 0;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return written[a] ? ram[a] : ((DW'(a) * 32'h9E3779B1) ^ salt);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_w) begin
            ram[bus.mem_addr]     <= bus.mem_din;
            written[bus.mem_addr] <= 1'b1;
        end
        bus.mem_dout <= ram_word(bus.mem_addr);
    end

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_ld[$];
    int checks = 0, errors = 0;
    int done_due = -1, remaining = 0;
    bit done_seen = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every RAM write, load pop and done pulse is matched to the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.mem_w) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.mem_addr, bus.mem_din);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write_addr", bus.mem_addr, e.addr);
                    chk("write_data", bus.mem_din, e.data);
                    remaining--;
                    if (remaining == 0) done_due = cyc + 1;
                end
            end
            if (bus.ld_valid && bus.ld_ready) begin
                if (exp_ld.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_load: data %0h, none expected", bus.ld_data);
                end else begin
                    chk("load_data", bus.ld_data, exp_ld.pop_front());
                    remaining--;
                    if (remaining == 0) done_due = cyc + 1;
                end
            end
            if (bus.done || cyc == done_due) begin
                chk("done_timing", bus.done, (cyc == done_due) ? 1 : 0);
                if (bus.done) done_seen = 1'b1;
            end
        end
    end

    // mode: 0 random, 1 latency/addr check, 2 stall, 3 zero-length, 4 fixed A0.. store
    task automatic run_req(input bit store, input int base, input int stride, input int len,
                           input int vprob, input int rprob, input int mode);
        int eff, acc, idx, n, r, issues;
        logic [AW-1:0] ea[$];
        logic [DW-1:0] sd[$];
        eff = STRIDE_EN ? stride : 1;
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = AW'((longint'(base) + longint'(i) * longint'(eff)) & AMASK);
            ea.push_back(a);
            if (store) begin
                d = (mode == 4) ? DW'(32'hA0 + i) : DW'($urandom);
                sd.push_back(d);
                exp_wr.push_back('{addr: a, data: d});
            end else begin
                exp_ld.push_back(ram_word(a));
            end
        end
        done_seen = 1'b0;
        remaining = len;
        chk("req_ready_before", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_store  = store;
        bus.req_base   = AW'(base);
        bus.req_stride = AW'(stride);
        bus.req_len    = LW'(len);
        @(negedge clk);
        acc = cyc;
        if (len == 0) done_due = acc + 1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        idx = 0; n = 0; issues = 0;
        while (!done_seen && n < 1500) begin
            if (store) begin
                bus.st_valid = (idx < len) && ($urandom_range(99) < vprob);
                bus.st_data  = (idx < len) ? sd[idx] : '0;
            end else begin
                bus.ld_ready = (mode == 2 && n < 10) ? 1'b0 : ($urandom_range(99) < rprob);
            end
            @(negedge clk);
            r = cyc - acc;
            if (bus.st_valid && bus.st_ready) idx++;
            if (mode == 1 && r >= 1 && r <= 4) begin
                chk("issue_addr", bus.mem_addr, ea[r-1]);
                chk("issue_is_read", bus.mem_w, 0);
            end
            if (mode == 1 && r == 2) chk("ld_valid_k1", bus.ld_valid, 0);
            if (mode == 1 && r == 3) chk("ld_valid_k2", bus.ld_valid, 1);
            if (mode == 2 && n < 10 && !bus.mem_w && bus.busy && bus.mem_addr != '0) issues++;
            if (mode == 2 && n == 10) begin
                checks++;
                if (issues < 1 || issues > 4) begin
                    errors++;
                    $display("FAIL stall_issues: got %0d reads while stalled, required 1..4", issues);
                end
            end
            if (mode == 3) begin
                chk("len0_addr", bus.mem_addr, 0);
                chk("len0_w", bus.mem_w, 0);
            end
            if (mode == 4 && r >= 1 && r <= 4) chk("store_consec", bus.mem_w, 1);
            @(posedge clk); #1;
            n++;
        end
        bus.st_valid = 1'b0;
        bus.ld_ready = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("queues_empty", exp_wr.size() + exp_ld.size(), 0);
        chk("req_ready_after", bus.req_ready, 1);
        chk("busy_after", bus.busy, 0);
        exp_wr.delete(); exp_ld.delete();
        remaining = 0;
        $display("txn %s base=%05h stride=%0d len=%0d mode=%0d cycles=%0d",
                 store ? "ST" : "LD", base, stride, len, mode, n);
    endtask

    task automatic reset_mid_store();
        int hs, n;
        for (int i = 0; i < 5; i++) exp_wr.push_back('{addr: AW'(32'h40 + i), data: DW'(32'hC0 + i)});
        remaining = 5;
        done_seen = 1'b0;
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_base = AW'(32'h40);
        bus.req_stride = AW'(1); bus.req_len = LW'(5);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        hs = 0; n = 0;
        while (hs < 2 && n < 20) begin
            bus.st_valid = 1'b1;
            bus.st_data  = DW'(32'hC0 + hs);
            @(negedge clk);
            if (bus.st_valid && bus.st_ready) hs++;
            @(posedge clk); #1;
            n++;
        end
        bus.st_data = DW'(32'hC2);
        exp_wr.delete();
        remaining = 0;
        done_due  = -1;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_w", bus.mem_w, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_st_ready", bus.st_ready, 0);
        bus.st_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_done", bus.done, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_done", done_seen, 0);
        $display("txn RST mid-store after %0d writes", hs);
    endtask

    initial begin
        salt = DW'($urandom);
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_base = '0;
        bus.req_stride = '0; bus.req_len = '0;
        bus.st_valid = 1'b0; bus.st_data = '0; bus.ld_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_mem_w", bus.mem_w, 0);
        chk("reset_ld_valid", bus.ld_valid, 0);
        chk("reset_st_ready", bus.st_ready, 0);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_done", bus.done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req(1'b1, 32'h00010, 1, 4, 100, 100, 4);
        run_req(1'b0, 32'h1FFFE, 1, 4, 100, 100, 1);
        run_req(1'b0, 32'h00100, 1, 8, 100, 100, 2);
        run_req(1'b1, 32'h00005, 3, 3, 100, 100, 0);
        run_req(1'b0, 32'h00005, 3, 3, 100, 100, 0);
        run_req(1'b0, 32'h00300, 1, 0, 100, 100, 3);
        reset_mid_store();
        run_req(1'b1, 32'h00040, 1, 5, 100, 100, 0);
        run_req(1'b0, 32'h00040, 1, 5, 100, 70, 0);
        run_req(1'b0, 32'h1FF80, 1, 127, 100, 80, 0);

        for (int t = 0; t < 30; t++) begin
            int st, b, s, l;
            st = $urandom_range(1);
            b  = $urandom_range(AMASK);
            s  = ($urandom_range(3) == 0) ? $urandom_range(AMASK) : $urandom_range(4);
            l  = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 40);
            run_req(st[0], b, s, l, $urandom_range(50, 100), $urandom_range(40, 100), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
